// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, h/v counters, registered sync/enable and strobes.
// Latency: decoded outputs are registered from next-state counters (zero skew to h_cnt/v_cnt).
// Backpressure: none; free-running, only reset stops the raster.
module vga_timing_gen #(
    parameter int unsigned H_SYNC_PULSE  = 96,
    parameter int unsigned H_BACK_PORCH  = 48,
    parameter int unsigned H_PERIOD      = 640,
    parameter int unsigned H_FRONT_PORCH = 16,
    parameter int unsigned V_SYNC_PULSE  = 2,
    parameter int unsigned V_BACK_PORCH  = 33,
    parameter int unsigned V_PERIOD      = 480,
    parameter int unsigned V_FRONT_PORCH = 10,
    parameter int unsigned CLK_DIV       = 2,
    parameter bit          SYNC_POL      = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [11:0] h_cnt,
    output logic [11:0] v_cnt,
    output logic        hsync,
    output logic        vsync,
    output logic        enable,
    output logic        pix_tick,
    output logic        line_tick,
    output logic        frame_tick
);

    localparam int unsigned H_TOTAL = H_SYNC_PULSE + H_BACK_PORCH + H_PERIOD + H_FRONT_PORCH;
    localparam int unsigned V_TOTAL = V_SYNC_PULSE + V_BACK_PORCH + V_PERIOD + V_FRONT_PORCH;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_SYNC_W  = 12'(H_SYNC_PULSE);
    localparam logic [11:0] V_SYNC_W  = 12'(V_SYNC_PULSE);
    localparam logic [11:0] H_ACT_LO  = 12'(H_SYNC_PULSE + H_BACK_PORCH);
    localparam logic [11:0] H_ACT_HI  = 12'(H_SYNC_PULSE + H_BACK_PORCH + H_PERIOD - 1);
    localparam logic [11:0] V_ACT_LO  = 12'(V_SYNC_PULSE + V_BACK_PORCH);
    localparam logic [11:0] V_ACT_HI  = 12'(V_SYNC_PULSE + V_BACK_PORCH + V_PERIOD - 1);

    // Raster dimensions must fit the 12-bit counters; the divider needs at least one clock per pixel.
    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 4096");
        end
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be >= 1");
        end
    endgenerate

    logic [DIV_W-1:0] div_q, div_d;
    logic [11:0]      h_q, h_d;
    logic [11:0]      v_q, v_d;
    logic             pix_q, pix_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             en_q, en_d;
    logic             lt_q, lt_d;
    logic             ft_q, ft_d;
    logic             h_wrap;

    // Next-state: divider, raster counters, and decodes taken from the next counter values.
    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        // pix_tick is registered so it stays low while in reset even when CLK_DIV is 1.
        pix_d  = (div_d == DIV_LAST);
        h_wrap = pix_q && (h_q == H_LAST);
        h_d    = h_q;
        v_d    = v_q;
        if (pix_q) begin
            h_d = h_wrap ? 12'd0 : h_q + 12'd1;
            if (h_wrap) begin
                v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
            end
        end
        hs_d = (h_d < H_SYNC_W) ? SYNC_POL : ~SYNC_POL;
        vs_d = (v_d < V_SYNC_W) ? SYNC_POL : ~SYNC_POL;
        en_d = (h_d >= H_ACT_LO) && (h_d <= H_ACT_HI) &&
               (v_d >= V_ACT_LO) && (v_d <= V_ACT_HI);
        lt_d = h_wrap;
        ft_d = h_wrap && (v_q == V_LAST);
    end

    // State and output registers; reset forces the raster origin and idle outputs at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            pix_q <= 1'b0;
            hs_q  <= SYNC_POL;
            vs_q  <= SYNC_POL;
            en_q  <= 1'b0;
            lt_q  <= 1'b0;
            ft_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            pix_q <= pix_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            en_q  <= en_d;
            lt_q  <= lt_d;
            ft_q  <= ft_d;
        end
    end

    assign h_cnt      = h_q;
    assign v_cnt      = v_q;
    assign hsync      = hs_q;
    assign vsync      = vs_q;
    assign enable     = en_q;
    assign pix_tick   = pix_q;
    assign line_tick  = lt_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two reduced-raster instances checked every clock against
// an arithmetic model (pixel count since reset -> h/v position and decodes).
`timescale 1ns/100ps
module tb_vga_timing_gen;

    // Instance A: active-low sync, two clocks per pixel.
    localparam int A_HS = 8, A_HB = 5, A_HP = 16, A_HF = 3;
    localparam int A_VS = 2, A_VB = 3, A_VP = 6,  A_VF = 2;
    localparam int A_D  = 2;
    localparam bit A_POL = 1'b0;
    // Instance B: active-high sync, one clock per pixel.
    localparam int B_HS = 5, B_HB = 3, B_HP = 10, B_HF = 2;
    localparam int B_VS = 1, B_VB = 2, B_VP = 4,  B_VF = 1;
    localparam int B_D  = 1;
    localparam bit B_POL = 1'b1;

    localparam int A_FRAME = A_D * (A_HS+A_HB+A_HP+A_HF) * (A_VS+A_VB+A_VP+A_VF);
    localparam int B_FRAME = B_D * (B_HS+B_HB+B_HP+B_HF) * (B_VS+B_VB+B_VP+B_VF);

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [11:0] a_h, a_v, b_h, b_v;
    logic a_hs, a_vs, a_en, a_pt, a_lt, a_ft;
    logic b_hs, b_vs, b_en, b_pt, b_lt, b_ft;

    int total = 0;
    int bad   = 0;
    int n     = 0;     // rising edges since reset release
    int a_last_ft = -1;
    int b_last_ft = -1;
    int a_en_cnt  = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    vga_timing_gen #(
        .H_SYNC_PULSE(A_HS), .H_BACK_PORCH(A_HB), .H_PERIOD(A_HP), .H_FRONT_PORCH(A_HF),
        .V_SYNC_PULSE(A_VS), .V_BACK_PORCH(A_VB), .V_PERIOD(A_VP), .V_FRONT_PORCH(A_VF),
        .CLK_DIV(A_D), .SYNC_POL(A_POL)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .h_cnt(a_h), .v_cnt(a_v), .hsync(a_hs), .vsync(a_vs),
        .enable(a_en), .pix_tick(a_pt), .line_tick(a_lt), .frame_tick(a_ft)
    );

    vga_timing_gen #(
        .H_SYNC_PULSE(B_HS), .H_BACK_PORCH(B_HB), .H_PERIOD(B_HP), .H_FRONT_PORCH(B_HF),
        .V_SYNC_PULSE(B_VS), .V_BACK_PORCH(B_VB), .V_PERIOD(B_VP), .V_FRONT_PORCH(B_VF),
        .CLK_DIV(B_D), .SYNC_POL(B_POL)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .h_cnt(b_h), .v_cnt(b_v), .hsync(b_hs), .vsync(b_vs),
        .enable(b_en), .pix_tick(b_pt), .line_tick(b_lt), .frame_tick(b_ft)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pixel periods completed after n edges: the counters advance on edges where the
    // registered strobe is already high, i.e. edges m with m % d == 0, m >= 2.
    function automatic int pixels(input int edges, input int d);
        if (edges < 1) return 0;
        if (d == 1) return edges - 1;
        return edges / d;
    endfunction

    task automatic check_one(input string nm, input int d,
                             input int hs, input int hb, input int hp, input int hf,
                             input int vs, input int vb, input int vp, input int vf,
                             input bit pol,
                             input logic [11:0] oh, input logic [11:0] ov,
                             input logic ohs, input logic ovs, input logic oen,
                             input logic opt, input logic olt, input logic oft);
        int ht, vt, p, eh, ev;
        bit adv, e_pt, e_hs, e_vs, e_en, e_lt, e_ft;
        ht   = hs + hb + hp + hf;
        vt   = vs + vb + vp + vf;
        p    = pixels(n, d);
        adv  = (p != pixels(n - 1, d));
        eh   = p % ht;
        ev   = (p / ht) % vt;
        e_pt = (n >= 1) && ((n % d) == d - 1);
        e_hs = (eh < hs) ? pol : ~pol;
        e_vs = (ev < vs) ? pol : ~pol;
        e_en = (eh >= hs + hb) && (eh < hs + hb + hp) && (ev >= vs + vb) && (ev < vs + vb + vp);
        e_lt = adv && (eh == 0);
        e_ft = e_lt && (ev == 0);
        chk({nm, ".h_cnt"},      32'(oh),  32'(eh));
        chk({nm, ".v_cnt"},      32'(ov),  32'(ev));
        chk({nm, ".hsync"},      32'(ohs), 32'(e_hs));
        chk({nm, ".vsync"},      32'(ovs), 32'(e_vs));
        chk({nm, ".enable"},     32'(oen), 32'(e_en));
        chk({nm, ".pix_tick"},   32'(opt), 32'(e_pt));
        chk({nm, ".line_tick"},  32'(olt), 32'(e_lt));
        chk({nm, ".frame_tick"}, 32'(oft), 32'(e_ft));
    endtask

    task automatic check_all();
        check_one("A", A_D, A_HS, A_HB, A_HP, A_HF, A_VS, A_VB, A_VP, A_VF, A_POL,
                  a_h, a_v, a_hs, a_vs, a_en, a_pt, a_lt, a_ft);
        check_one("B", B_D, B_HS, B_HB, B_HP, B_HF, B_VS, B_VB, B_VP, B_VF, B_POL,
                  b_h, b_v, b_hs, b_vs, b_en, b_pt, b_lt, b_ft);
        // Frame-level statistics: period and number of visible pixels per frame.
        if (a_ft === 1'b1) begin
            if (a_last_ft < 0) begin
                chk("A.first_frame_delay", 32'(n), 32'(A_FRAME));
            end else begin
                chk("A.frame_period", 32'(n - a_last_ft), 32'(A_FRAME));
                chk("A.visible_pixels", 32'(a_en_cnt), 32'(A_HP * A_VP));
            end
            a_last_ft = n;
            a_en_cnt  = 0;
        end
        if (a_pt === 1'b1 && a_en === 1'b1) a_en_cnt++;
        if (b_ft === 1'b1) begin
            if (b_last_ft >= 0) chk("B.frame_period", 32'(n - b_last_ft), 32'(B_FRAME));
            b_last_ft = n;
        end
    endtask

    task automatic run(input int k);
        repeat (k) begin
            @(negedge clk);
            check_all();
        end
    endtask

    // Assert reset between edges, check reset values before the next edge, hold, release.
    task automatic async_reset(input int offset, input int hold);
        @(negedge clk);
        #(offset);
        rst_n = 1'b0;
        a_last_ft = -1;
        b_last_ft = -1;
        a_en_cnt  = 0;
        #1;
        chk("A.rst_h_cnt",  32'(a_h),  32'd0);
        chk("A.rst_v_cnt",  32'(a_v),  32'd0);
        chk("A.rst_hsync",  32'(a_hs), 32'(A_POL));
        chk("A.rst_vsync",  32'(a_vs), 32'(A_POL));
        chk("A.rst_enable", 32'(a_en), 32'd0);
        chk("A.rst_ticks",  32'({a_pt, a_lt, a_ft}), 32'd0);
        chk("B.rst_hsync",  32'(b_hs), 32'(B_POL));
        chk("B.rst_ticks",  32'({b_pt, b_lt, b_ft}), 32'd0);
        check_all();
        run(hold);
        @(negedge clk);
        #(offset);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        // Power-on reset, then a clean release.
        rst_n = 1'b0;
        run(3);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        // Two full frames of A (and many of B), checking every clock.
        run(2 * A_FRAME + 40);

        // Drive A to a mid-frame position, then reset between clock edges.
        guard = 0;
        while (!(a_h == 12'd20 && a_v == 12'd7) && guard < 2 * A_FRAME) begin
            @(negedge clk);
            check_all();
            guard++;
        end
        chk("A.reach_mid_frame", 32'(guard < 2 * A_FRAME), 32'd1);
        async_reset(2, 2);
        run(A_FRAME + 40);

        // Random run lengths and reset points.
        for (int i = 0; i < 4; i++) begin
            run($urandom_range(30, A_FRAME));
            async_reset($urandom_range(1, 3), $urandom_range(0, 3));
        end
        run(2 * A_FRAME + 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA 640x480@60 timing from the system clock.
- Produces the h_cnt/v_cnt raster counters and the enable (active-video) flag that the graphics generator consumes.
- Also produces the hsync/vsync pins and pixel/line/frame strobes for the pong game logic.
- Counter origin: count 0 is the first pixel of the sync pulse, so active video starts at h = SYNC + BACK_PORCH and v = SYNC + BACK_PORCH.

Parameters:
- H_SYNC_PULSE, 96, horizontal sync width in pixels
- H_BACK_PORCH, 48, horizontal back porch in pixels
- H_PERIOD, 640, active pixels per line
- H_FRONT_PORCH, 16, horizontal front porch in pixels
- V_SYNC_PULSE, 2, vertical sync width in lines
- V_BACK_PORCH, 33, vertical back porch in lines
- V_PERIOD, 480, active lines per frame
- V_FRONT_PORCH, 10, vertical front porch in lines
- CLK_DIV, 2, system clocks per pixel (50 MHz -> 25 MHz); must be >= 1
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- h_cnt  output  12  horizontal pixel counter, 0..H_TOTAL-1
- v_cnt  output  12  vertical line counter, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, SYNC_POL level while active
- vsync  output  1  vertical sync, SYNC_POL level while active
- enable  output  1  high inside the active 640x480 window
- pix_tick  output  1  one-clk strobe, one per pixel period
- line_tick  output  1  one-clk strobe in the first clk where h_cnt==0
- frame_tick  output  1  one-clk strobe in the first clk where h_cnt==0 and v_cnt==0

Behaviour:
- Interface fixed: one clock (clk); reset rst_n is asynchronous and active-low.
- Derived constants:
  - H_TOTAL = H_SYNC_PULSE + H_BACK_PORCH + H_PERIOD + H_FRONT_PORCH (800).
  - V_TOTAL = V_SYNC_PULSE + V_BACK_PORCH + V_PERIOD + V_FRONT_PORCH (525).
  - Both must be <= 4096; elaboration error otherwise.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_tick is high during the clk where div_cnt==CLK_DIV-1.
  - CLK_DIV=1: pix_tick is high in every cycle after reset.
- Counters advance only on clock edges where pix_tick is high:
  - h_cnt increments; at H_TOTAL-1 it wraps to 0.
  - On that h wrap, v_cnt increments; at V_TOTAL-1 it wraps to 0.
  - v_cnt never changes without an h wrap.
  - Counters are unsigned and zero-extended to 12 bits.
- Decoded outputs are registered. They are computed from the next-state counter values, so they are exactly aligned with the h_cnt/v_cnt present in the same cycle (zero skew):
  - hsync = SYNC_POL when h_cnt < H_SYNC_PULSE, else ~SYNC_POL.
  - vsync = SYNC_POL when v_cnt < V_SYNC_PULSE, else ~SYNC_POL.
  - enable = 1 iff H_SYNC_PULSE+H_BACK_PORCH <= h_cnt <= H_SYNC_PULSE+H_BACK_PORCH+H_PERIOD-1 and V_SYNC_PULSE+V_BACK_PORCH <= v_cnt <= V_SYNC_PULSE+V_BACK_PORCH+V_PERIOD-1. Defaults: h 144..783, v 35..514.
- Strobes:
  - line_tick is high for one clk, the first clk after the edge that wrapped h_cnt to 0.
  - frame_tick is high for one clk, in the same cycle as line_tick when v_cnt also wrapped to 0.
  - frame_tick always coincides with line_tick.
  - Neither strobe is asserted out of reset. The first line_tick/frame_tick comes at the first wrap.
- Reset (async assert, any time):
  - div_cnt=0, h_cnt=0, v_cnt=0.
  - hsync=vsync=SYNC_POL, enable=0.
  - pix_tick=line_tick=frame_tick=0.
- Reset release:
  - Counting starts on the first rising edge with rst_n high.
  - Default CLK_DIV=2: pix_tick first high in the 2nd clk after release.
- Reset mid-frame:
  - Outputs go to reset values immediately (no clk needed).
  - After release the raster restarts cleanly from (0,0), with no partial strobe.

Test Plan:
- Reset: hold rst_n=0 -> h_cnt=0, v_cnt=0, hsync=0, vsync=0, enable=0, all ticks 0. Release -> pix_tick pulses every 2nd clk; h_cnt reaches 1 after the first pix_tick.
- Horizontal line: run 1 line -> hsync low for h_cnt 0..95 and high for 96..799; line_tick period = 1600 clk; h_cnt max observed = 799.
- Active window: run 1 full frame -> enable high only for h 144..783 with v 35..514; enable-high pixel count = 307200 (count pix_tick cycles with enable=1).
- Vertical/frame: vsync low for v_cnt 0..1 only; v_cnt max = 524; frame_tick period = 840000 clk; frame_tick coincides with line_tick with h_cnt=0, v_cnt=0.
- Mid-frame reset: assert rst_n=0 asynchronously at h_cnt=400, v_cnt=200, between clock edges -> outputs return to reset values before the next edge. Release -> next frame_tick exactly 840000 clk later.
- Variant CLK_DIV=1, SYNC_POL=1: pix_tick constantly high; line period = 800 clk; hsync high for h_cnt 0..95; frame period = 420000 clk.
